// File: rtl/ram16_bist_pkg.sv
// Shared types and constants for the 16x2 RAM March C- self-test.
// Holds the FSM state type and the per-element march table.
package ram16_bist_pkg;

    localparam int DEPTH        = 16;
    localparam int ADDR_W       = $clog2(DEPTH);
    localparam int NUM_ELEM     = 6;
    localparam int TOTAL_CYCLES = 160;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    // rd_inv/wr_inv select ~DATA_BG instead of DATA_BG for the read expect / write value.
    typedef struct packed {
        logic down;
        logic rd_inv;
        logic wr_inv;
        logic has_rd;
        logic has_wr;
    } march_elem_t;

    localparam march_elem_t MARCH_TABLE [NUM_ELEM] = '{
        '{down: 1'b0, rd_inv: 1'b0, wr_inv: 1'b0, has_rd: 1'b0, has_wr: 1'b1},
        '{down: 1'b0, rd_inv: 1'b0, wr_inv: 1'b1, has_rd: 1'b1, has_wr: 1'b1},
        '{down: 1'b0, rd_inv: 1'b1, wr_inv: 1'b0, has_rd: 1'b1, has_wr: 1'b1},
        '{down: 1'b1, rd_inv: 1'b0, wr_inv: 1'b1, has_rd: 1'b1, has_wr: 1'b1},
        '{down: 1'b1, rd_inv: 1'b1, wr_inv: 1'b0, has_rd: 1'b1, has_wr: 1'b1},
        '{down: 1'b0, rd_inv: 1'b0, wr_inv: 1'b0, has_rd: 1'b1, has_wr: 1'b0}
    };

endpackage

// File: rtl/ram16_bist_addr_gen.sv
// March address counter: load, up/down step with natural 4-bit wrap.
// tc flags the terminal address of the current direction (15 up, 0 down).
module ram16_bist_addr_gen
    import ram16_bist_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_val,
    input  logic              step,
    input  logic              down,
    output logic [ADDR_W-1:0] addr,
    output logic              tc
);

    always_ff @(posedge clk) begin
        if (rst) begin
            addr <= '0;
        end else if (load) begin
            addr <= load_val;
        end else if (step) begin
            addr <= down ? addr - 1'b1 : addr + 1'b1;
        end
    end

    assign tc = down ? (addr == '0) : (addr == ADDR_W'(DEPTH - 1));

endmodule

// File: rtl/ram16x2_march_bist.sv
// March C- BIST and functional mux for a 16x2 async-read RAM; 160 test cycles, DONE in the next.
// RAM16_BIST_STOP_ON_FAIL_EN: end the run on the first mismatch instead of finishing the sequence.
module ram16x2_march_bist
    import ram16_bist_pkg::*;
#(
    parameter logic [1:0] DATA_BG = 2'b00
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [3:0] FUNC_A,
    input  logic [1:0] FUNC_D,
    input  logic       FUNC_WE,
    output logic [1:0] FUNC_O,
    output logic [3:0] RAM_A,
    output logic [1:0] RAM_D,
    output logic       RAM_WE,
    input  logic [1:0] RAM_O,
    output logic       BUSY,
    output logic       DONE,
    output logic       FAIL,
    output logic [3:0] FAIL_ADDR,
    output logic [1:0] FAIL_BITS,
    output logic [2:0] FAIL_ELEM
);

    state_t            state, state_nxt;
    logic [2:0]        elem, elem_nxt, elem_inc;
    logic              phase, phase_nxt;
    logic [ADDR_W-1:0] addr, addr_load_val;
    logic              addr_load, addr_step, addr_tc;
    logic              bist_we, bist_we_nxt;
    logic [1:0]        bist_d, bist_d_nxt;
    logic              rd_cycle, mismatch;
    logic [1:0]        rd_exp;

    ram16_bist_addr_gen u_addr_gen (
        .clk      (CLK),
        .rst      (RST),
        .load     (addr_load),
        .load_val (addr_load_val),
        .step     (addr_step),
        .down     (MARCH_TABLE[elem].down),
        .addr     (addr),
        .tc       (addr_tc)
    );

    assign elem_inc = elem + 3'd1;
    assign rd_cycle = (state == ST_RUN) && MARCH_TABLE[elem].has_rd && !phase;
    assign rd_exp   = MARCH_TABLE[elem].rd_inv ? ~DATA_BG : DATA_BG;
    assign mismatch = rd_cycle && (RAM_O != rd_exp);

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // phase 0 is the read half of an r,w element; single-op elements stay in phase 0.
    always_comb begin
        state_nxt     = state;
        elem_nxt      = elem;
        phase_nxt     = phase;
        addr_load     = 1'b0;
        addr_load_val = '0;
        addr_step     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (START) begin
                    state_nxt = ST_RUN;
                    elem_nxt  = '0;
                    phase_nxt = 1'b0;
                    addr_load = 1'b1;
                end
            end
            ST_RUN: begin
                if (MARCH_TABLE[elem].has_rd && MARCH_TABLE[elem].has_wr && !phase) begin
                    phase_nxt = 1'b1;
                end else begin
                    phase_nxt = 1'b0;
                    if (!addr_tc) begin
                        addr_step = 1'b1;
                    end else if (elem == 3'(NUM_ELEM - 1)) begin
                        state_nxt = ST_DONE;
                    end else begin
                        elem_nxt      = elem_inc;
                        addr_load     = 1'b1;
                        addr_load_val = {ADDR_W{MARCH_TABLE[elem_inc].down}};
                    end
                end
`ifdef RAM16_BIST_STOP_ON_FAIL_EN
                if (mismatch) begin
                    state_nxt = ST_DONE;
                end
`endif
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
        bist_we_nxt = (state_nxt == ST_RUN) && MARCH_TABLE[elem_nxt].has_wr &&
                      (phase_nxt || !MARCH_TABLE[elem_nxt].has_rd);
        bist_d_nxt  = MARCH_TABLE[elem_nxt].wr_inv ? ~DATA_BG : DATA_BG;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            elem      <= '0;
            phase     <= 1'b0;
            bist_we   <= 1'b0;
            bist_d    <= '0;
            FAIL      <= 1'b0;
            FAIL_ADDR <= '0;
            FAIL_BITS <= '0;
            FAIL_ELEM <= '0;
        end else begin
            elem    <= elem_nxt;
            phase   <= phase_nxt;
            bist_we <= bist_we_nxt;
            bist_d  <= bist_d_nxt;
            if (state == ST_IDLE && START) begin
                FAIL      <= 1'b0;
                FAIL_ADDR <= '0;
                FAIL_BITS <= '0;
                FAIL_ELEM <= '0;
            end else if (mismatch && !FAIL) begin
                FAIL      <= 1'b1;
                FAIL_ADDR <= addr;
                FAIL_BITS <= RAM_O ^ rd_exp;
                FAIL_ELEM <= elem;
            end
        end
    end

    assign BUSY   = (state == ST_RUN);
    assign DONE   = (state == ST_DONE);
    assign RAM_A  = BUSY ? addr    : FUNC_A;
    assign RAM_D  = BUSY ? bist_d  : FUNC_D;
    assign RAM_WE = BUSY ? bist_we : FUNC_WE;
    assign FUNC_O = RAM_O;

endmodule

// File: tb/tb_ram16x2_march_bist.sv
// Bench for ram16x2_march_bist: behavioural RAM with stuck-at injection, march reference model,
// random functional traffic and random fault placement.
`timescale 1ns/1ps
module tb_ram16x2_march_bist;
    import ram16_bist_pkg::*;

    localparam logic [1:0] BG = 2'b00;

    logic       CLK = 1'b0;
    logic       RST, START, FUNC_WE, RAM_WE, BUSY, DONE, FAIL;
    logic [3:0] FUNC_A, RAM_A, FAIL_ADDR;
    logic [1:0] FUNC_D, FUNC_O, RAM_D, RAM_O, FAIL_BITS;
    logic [2:0] FAIL_ELEM;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 CLK = ~CLK;

    ram16x2_march_bist #(.DATA_BG(BG)) dut (
        .CLK(CLK), .RST(RST), .START(START),
        .FUNC_A(FUNC_A), .FUNC_D(FUNC_D), .FUNC_WE(FUNC_WE), .FUNC_O(FUNC_O),
        .RAM_A(RAM_A), .RAM_D(RAM_D), .RAM_WE(RAM_WE), .RAM_O(RAM_O),
        .BUSY(BUSY), .DONE(DONE), .FAIL(FAIL),
        .FAIL_ADDR(FAIL_ADDR), .FAIL_BITS(FAIL_BITS), .FAIL_ELEM(FAIL_ELEM)
    );

    // Behavioural 16x2 RAM: synchronous write, asynchronous read, optional stuck-at bit.
    logic [1:0] mem [16];
    logic       flt_en, flt_bit, flt_val;
    logic [3:0] flt_addr;

    always @(posedge CLK) if (RAM_WE) mem[RAM_A] <= RAM_D;

    always_comb begin
        RAM_O = mem[RAM_A];
        if (flt_en && RAM_A == flt_addr) RAM_O[flt_bit] = flt_val;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // March C- written as element lists: direction, read?, read value, write?, write value.
    bit e_down [6] = '{0, 0, 0, 1, 1, 0};
    bit e_rd   [6] = '{0, 1, 1, 1, 1, 1};
    bit e_rv   [6] = '{0, 0, 1, 0, 1, 0};
    bit e_wr   [6] = '{1, 1, 1, 1, 1, 0};
    bit e_wv   [6] = '{0, 1, 0, 1, 0, 0};

    typedef struct { logic [3:0] a; logic we; logic [1:0] d; } op_t;
    op_t        sched[$];
    int         exp_fail_cyc;
    logic [3:0] exp_fa;
    logic [1:0] exp_fb;
    logic [2:0] exp_fe;
    logic [1:0] ref_mem [16];

    task automatic build_model();
        logic [1:0] m [16];
        logic [1:0] got, want;
        int cyc, a;
        op_t op;
        cyc = 0;
        sched.delete();
        exp_fail_cyc = 0; exp_fa = '0; exp_fb = '0; exp_fe = '0;
        for (int i = 0; i < 16; i++) m[i] = BG;
        for (int e = 0; e < 6; e++) begin
            for (int i = 0; i < 16; i++) begin
                a = e_down[e] ? 15 - i : i;
                if (e_rd[e]) begin
                    got  = m[a];
                    want = e_rv[e] ? ~BG : BG;
                    if (flt_en && a == int'(flt_addr)) got[flt_bit] = flt_val;
                    cyc++;
                    op.a = 4'(a); op.we = 1'b0; op.d = 2'b00;
                    sched.push_back(op);
                    if (got != want && exp_fail_cyc == 0) begin
                        exp_fail_cyc = cyc; exp_fa = 4'(a); exp_fb = got ^ want; exp_fe = 3'(e);
                    end
                end
                if (e_wr[e]) begin
                    m[a] = e_wv[e] ? ~BG : BG;
                    cyc++;
                    op.a = 4'(a); op.we = 1'b1; op.d = m[a];
                    sched.push_back(op);
                end
            end
        end
    endtask

    task automatic drive_func(input int we_mode);
        FUNC_A  = 4'($urandom);
        FUNC_D  = 2'($urandom);
        FUNC_WE = (we_mode == 0) ? 1'b0 : (we_mode == 1) ? 1'b1 : 1'($urandom);
    endtask

    // we_mode: 0 no functional writes, 1 always, 2 random. rst_at: cycle to assert RST (0 = none).
    task automatic do_run(input int we_mode, input bit hold, input int rst_at);
        int len;
        build_model();
        len = TOTAL_CYCLES;
`ifdef RAM16_BIST_STOP_ON_FAIL_EN
        if (exp_fail_cyc != 0) len = exp_fail_cyc;
`endif
        @(negedge CLK);
        START = 1'b1;
        drive_func(we_mode);
        for (int c = 1; c <= len; c++) begin
            @(negedge CLK);
            if (!hold) START = 1'b0;
            check("busy", BUSY, 1'b1);
            check("done_early", DONE, 1'b0);
            check("ram_a", RAM_A, sched[c-1].a);
            check("ram_we", RAM_WE, sched[c-1].we);
            if (sched[c-1].we) check("ram_d", RAM_D, sched[c-1].d);
            check("fail_live", FAIL, exp_fail_cyc != 0 && c > exp_fail_cyc);
            if (c == rst_at) begin
                RST = 1'b1;
                @(negedge CLK);
                check("rst_busy", BUSY, 1'b0);
                check("rst_done", DONE, 1'b0);
                check("rst_fail", FAIL, 1'b0);
                RST = 1'b0;
                repeat (2) begin
                    @(negedge CLK);
                    check("rst_no_done", DONE, 1'b0);
                    check("rst_idle", BUSY, 1'b0);
                end
                return;
            end
            drive_func(we_mode);
        end
        @(negedge CLK);
        check("done", DONE, 1'b1);
        check("done_busy", BUSY, 1'b0);
        check("done_mux_we", RAM_WE, FUNC_WE);
        check("fail", FAIL, exp_fail_cyc != 0);
        check("fail_addr", FAIL_ADDR, exp_fa);
        check("fail_bits", FAIL_BITS, exp_fb);
        check("fail_elem", FAIL_ELEM, exp_fe);
        if (hold) begin
            @(negedge CLK);
            check("hold_idle_busy", BUSY, 1'b0);
            check("hold_idle_done", DONE, 1'b0);
            @(negedge CLK);
            START = 1'b0;
            check("restart_busy", BUSY, 1'b1);
            check("restart_a", RAM_A, 4'd0);
            check("restart_we", RAM_WE, 1'b1);
            for (int k = 0; k < 200; k++) begin
                @(negedge CLK);
                if (DONE) break;
            end
            check("restart_done", DONE, 1'b1);
        end else begin
            START = 1'b0;
            @(negedge CLK);
            check("done_pulse_end", DONE, 1'b0);
            check("fail_stable", FAIL, exp_fail_cyc != 0);
            check("fail_addr_stable", FAIL_ADDR, exp_fa);
        end
    endtask

    initial begin
        RST = 1'b1; START = 1'b0; FUNC_A = '0; FUNC_D = '0; FUNC_WE = 1'b0;
        flt_en = 1'b0; flt_addr = '0; flt_bit = 1'b0; flt_val = 1'b0;
        repeat (3) @(negedge CLK);
        check("rst_busy0", BUSY, 1'b0);
        check("rst_done0", DONE, 1'b0);
        check("rst_fail0", FAIL, 1'b0);
        check("rst_fa0", FAIL_ADDR, 4'd0);
        check("rst_fb0", FAIL_BITS, 2'd0);
        check("rst_fe0", FAIL_ELEM, 3'd0);
        FUNC_A = 4'd9; FUNC_D = 2'b01; FUNC_WE = 1'b0;
        #1;
        check("rst_mux_a", RAM_A, 4'd9);
        check("rst_mux_d", RAM_D, 2'b01);
        check("rst_mux_we", RAM_WE, 1'b0);
        @(negedge CLK);
        RST = 1'b0;

        // Functional pass-through in idle
        FUNC_A = 4'd3; FUNC_D = 2'b10; FUNC_WE = 1'b1;
        #1;
        check("mux_a", RAM_A, 4'd3);
        check("mux_d", RAM_D, 2'b10);
        check("mux_we", RAM_WE, 1'b1);
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            FUNC_A = 4'(i); FUNC_D = 2'($urandom); FUNC_WE = 1'b1;
            ref_mem[i] = FUNC_D;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            drive_func(2);
            #1;
            check("func_o", FUNC_O, ref_mem[FUNC_A]);
            if (FUNC_WE) ref_mem[FUNC_A] = FUNC_D;
        end
        @(negedge CLK);
        FUNC_WE = 1'b0;

        do_run(2, 1'b0, 0);
        do_run(1, 1'b0, 0);

        // Bit0 stuck-at-1 at address 5
        flt_en = 1'b1; flt_addr = 4'd5; flt_bit = 1'b0; flt_val = 1'b1;
        do_run(0, 1'b0, 0);
        check("plan_fail", FAIL, 1'b1);
        check("plan_fa", FAIL_ADDR, 4'd5);
        check("plan_fb", FAIL_BITS, 2'b01);
        check("plan_fe", FAIL_ELEM, 3'd1);
`ifdef RAM16_BIST_STOP_ON_FAIL_EN
        check("stop_quiet_we", RAM_WE, 1'b0);
`endif
        flt_en = 1'b0;

        do_run(2, 1'b0, 0);
        do_run(2, 1'b0, 50);
        do_run(2, 1'b0, 0);
        do_run(2, 1'b1, 0);

        for (int r = 0; r < 4; r++) begin
            flt_en   = 1'b1;
            flt_addr = 4'($urandom);
            flt_bit  = 1'($urandom);
            flt_val  = 1'($urandom);
`ifdef RAM16_BIST_STOP_ON_FAIL_EN
            do_run(0, 1'b0, 0);
`else
            do_run(2, 1'b0, 0);
`endif
        end
        flt_en = 1'b0;
        do_run(2, 1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
